// File: rtl/bitty_test_monitor_pkg.sv
// Shared constants, types and helpers for the bitty end-of-test monitor.
package bitty_test_monitor_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned CW   = 32;
    localparam int unsigned STW  = 3;

    localparam logic [AW-1:0] REG_TESTNUM = AW'(3);
    localparam logic [AW-1:0] REG_DONE    = AW'(26);
    localparam logic [AW-1:0] REG_PASS    = AW'(27);

    localparam logic [STW-1:0] ST_RUN    = 3'd0;
    localparam logic [STW-1:0] ST_SETTLE = 3'd1;
    localparam logic [STW-1:0] ST_PASS   = 3'd2;
    localparam logic [STW-1:0] ST_FAIL   = 3'd3;
    localparam logic [STW-1:0] ST_TOUT   = 3'd4;

    typedef struct packed {
        logic            we;
        logic [AW-1:0]   waddr;
        logic [XLEN-1:0] wdata;
    } rf_wr_t;

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + CW'(1);
    endfunction

    function automatic logic is_terminal(input logic [STW-1:0] st);
        return (st == ST_PASS) || (st == ST_FAIL) || (st == ST_TOUT);
    endfunction

endpackage

// File: rtl/bitty_test_monitor_if.sv
// Register-file write port as seen by the test monitor.
interface bitty_test_monitor_if;
    import bitty_test_monitor_pkg::*;

    logic            rf_we;
    logic [AW-1:0]   rf_waddr;
    logic [XLEN-1:0] rf_wdata;

    modport master (output rf_we, output rf_waddr, output rf_wdata);
    modport slave  (input  rf_we, input  rf_waddr, input  rf_wdata);

endinterface

// File: rtl/bitty_test_monitor_reg_shadow.sv
// Compare-and-capture shadow of one architectural register from the write port.
module bitty_reg_shadow
    import bitty_test_monitor_pkg::*;
#(
    parameter logic [AW-1:0] IDX = AW'(1)
) (
    input  logic            clk,
    input  logic            rst,
    input  rf_wr_t          wr_i,
    output logic [XLEN-1:0] val_o
);

    logic [XLEN-1:0] val_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            val_q <= '0;
        end else if (wr_i.we && (wr_i.waddr == IDX)) begin
            val_q <= wr_i.wdata;
        end
    end

    assign val_o = val_q;

endmodule

// File: rtl/bitty_test_monitor.sv
// End-of-test monitor: shadows x3/x26/x27 and decides pass/fail/timeout in hardware.
module bitty_test_monitor
    import bitty_test_monitor_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 5000,
    parameter int unsigned SETTLE_CYCLES  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    bitty_test_monitor_if.slave  rf_if,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout,
    output logic [XLEN-1:0]      fail_inst,
    output logic [CW-1:0]        cycle_count
);

    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);

    rf_wr_t          wr;
    logic [XLEN-1:0] sh_x3;
    logic [XLEN-1:0] sh_x26;
    logic [XLEN-1:0] sh_x27;

    logic [STW-1:0]  state_q,  state_d;
    logic [CW-1:0]   settle_q, settle_d;
    logic [CW-1:0]   cnt_q,    cnt_d;
    logic [XLEN-1:0] fail_q,   fail_d;
    logic            done_q, pass_q, tout_q;

    assign wr.we    = rf_if.rf_we;
    assign wr.waddr = rf_if.rf_waddr;
    assign wr.wdata = rf_if.rf_wdata;

    bitty_reg_shadow #(.IDX(REG_TESTNUM)) u_sh_x3 (
        .clk(clk), .rst(rst), .wr_i(wr), .val_o(sh_x3)
    );
    bitty_reg_shadow #(.IDX(REG_DONE)) u_sh_x26 (
        .clk(clk), .rst(rst), .wr_i(wr), .val_o(sh_x26)
    );
    bitty_reg_shadow #(.IDX(REG_PASS)) u_sh_x27 (
        .clk(clk), .rst(rst), .wr_i(wr), .val_o(sh_x27)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_RUN;
            settle_q <= '0;
            cnt_q    <= '0;
            fail_q   <= '0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            cnt_q    <= cnt_d;
            fail_q   <= fail_d;
            done_q   <= is_terminal(state_d);
            pass_q   <= (state_d == ST_PASS);
            tout_q   <= (state_d == ST_TOUT);
        end
    end

    // Next-state logic; the cycle counter freezes on the edge that enters a terminal state.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        cnt_d    = cnt_q;
        fail_d   = fail_q;

        case (state_q)
            ST_RUN: begin
                if (sh_x26 == XLEN'(1)) begin
                    state_d  = ST_SETTLE;
                    settle_d = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = ST_TOUT;
                end
            end
            ST_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    if (sh_x27 == XLEN'(1)) begin
                        state_d = ST_PASS;
                    end else begin
                        state_d = ST_FAIL;
                        fail_d  = sh_x3;
                    end
                end else begin
                    settle_d = sat_inc(settle_q);
                end
            end
            default: begin
            end
        endcase

        if (!is_terminal(state_d)) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    assign done        = done_q;
    assign pass        = pass_q;
    assign timeout     = tout_q;
    assign fail_inst   = fail_q;
    assign cycle_count = cnt_q;

endmodule
